// File: rtl/cache_pkg.sv
// cache_pkg: shared defaults, FSM encoding and address field helpers for mem_cache
package cache_pkg;
  localparam int SETS = 64;
  localparam int INDEX_W = 6;
  localparam int TAG_W = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2} state_t;
  function automatic logic [31:0] index_of(input logic [31:0] a, input int iw);
    return (a >> 2) & ((32'd1 << iw) - 32'd1);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a, input int iw, input int tw);
    return (a >> (iw + 2)) & ((32'd1 << tw) - 32'd1);
  endfunction
endpackage

// File: rtl/cache_set_store.sv
// cache_set_store: two-way valid/tag/data arrays plus per-set LRU bit
module cache_set_store #(
  parameter int SETS = cache_pkg::SETS,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_W-1:0]      index,
  input  logic                    fill_en,
  input  logic                    upd_en,
  input  logic                    touch_en,
  input  logic                    way,
  input  logic [TAG_W-1:0]        tag_in,
  input  logic [31:0]             data_in,
  output logic [1:0]              valid,
  output logic [1:0][TAG_W-1:0]   tags,
  output logic [1:0][31:0]        datas,
  output logic                    lru
);
  logic [SETS-1:0][1:0] valid_mem;
  logic [SETS-1:0] lru_mem;
  logic [TAG_W-1:0] tag_mem [SETS][2];
  logic [31:0] data_mem [SETS][2];
  // valid and LRU bits are the only state that reset must clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_mem <= '0;
      lru_mem <= '0;
    end else begin
      if (fill_en) valid_mem[index][way] <= 1'b1;
      if (touch_en) lru_mem[index] <= ~way;
    end
  // tag written only on fill; data on fill or write-through hit
  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[index][way] <= tag_in;
    if (fill_en || upd_en) data_mem[index][way] <= data_in;
  end
  assign valid = valid_mem[index];
  assign lru = lru_mem[index];
  assign tags = {tag_mem[index][1], tag_mem[index][0]};
  assign datas = {data_mem[index][1], data_mem[index][0]};
endmodule

// File: rtl/mem_cache.sv
// mem_cache: two-way write-through, no-write-allocate data cache in front of the SRAM controller
module mem_cache #(
  parameter int SETS = cache_pkg::SETS,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        freeze,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
);
  import cache_pkg::*;
  state_t state, next;
  logic [31:0] look;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [1:0] valid;
  logic [1:0][TAG_W-1:0] tags;
  logic [1:0][31:0] datas;
  logic lru, hit0, hit1, hit, hit_way, victim;
  logic fill_en, upd_en, touch_en, way, latch;
  // idle looks up the live address; busy states resolve against the latched one
  assign look = state == IDLE ? address : sram_address;
  assign index = INDEX_W'(index_of(look, INDEX_W));
  assign tag = TAG_W'(tag_of(look, INDEX_W, TAG_W));
  assign hit0 = valid[0] && tags[0] == tag;
  assign hit1 = valid[1] && tags[1] == tag;
  assign hit = hit0 || hit1;
  assign hit_way = hit1;
  assign victim = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : lru;
  assign sram_rd_en = state == RD_MISS;
  assign sram_wr_en = state == WR_THRU;
  cache_set_store #(.SETS(SETS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) store (
    .clk(clk), .rst(rst), .index(index), .fill_en(fill_en), .upd_en(upd_en),
    .touch_en(touch_en), .way(way), .tag_in(tag),
    .data_in(state == WR_THRU ? sram_write_data : sram_read_data),
    .valid(valid), .tags(tags), .datas(datas), .lru(lru)
  );
  // next state, stall and array write controls
  always_comb begin
    next = state;
    freeze = 1'b0;
    read_data = valid[0] ? datas[0] : '0;
    fill_en = 1'b0;
    upd_en = 1'b0;
    touch_en = 1'b0;
    way = hit_way;
    latch = 1'b0;
    case (state)
      IDLE:
        if (mem_wr_en || (mem_rd_en && !hit)) begin
          latch = 1'b1;
          freeze = rst;
          next = mem_wr_en ? WR_THRU : RD_MISS;
        end else if (mem_rd_en) begin
          read_data = datas[hit_way];
          touch_en = 1'b1;
        end
      RD_MISS: begin
        freeze = !sram_ready;
        if (sram_ready) begin
          fill_en = 1'b1;
          touch_en = 1'b1;
          way = victim;
          read_data = sram_read_data;
          next = IDLE;
        end
      end
      WR_THRU: begin
        freeze = !sram_ready;
        if (sram_ready) begin
          upd_en = hit;
          touch_en = hit;
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  // request latches feeding the SRAM controller
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sram_address <= '0;
      sram_write_data <= '0;
    end else if (latch) begin
      sram_address <= address;
      if (mem_wr_en) sram_write_data <= write_data;
    end
endmodule

// File: tb/tb_mem_cache.sv
// tb_mem_cache: randomized check of mem_cache against a set-level cache and SRAM model
module tb_mem_cache;
  logic clk = 0, rst = 0, mem_rd_en = 0, mem_wr_en = 0;
  logic [31:0] address = 0, write_data = 0, sram_read_data = 0;
  logic [31:0] read_data, sram_address, sram_write_data;
  logic freeze, sram_rd_en, sram_wr_en, sram_ready;
  int total = 0, bad = 0, cnt;
  bit mv[64][2];
  bit [9:0] mt[64][2];
  bit [31:0] md[64][2];
  bit ml[64];
  bit [31:0] smem [bit [29:0]];

  always #5 clk = ~clk;

  // controller model: ready on the fifth cycle after it first sees an enable
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= 0;
    else cnt <= (sram_rd_en || sram_wr_en) ? cnt + 1 : 0;
  assign sram_ready = (sram_rd_en || sram_wr_en) && cnt == 5;

  mem_cache dut (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .freeze(freeze), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready)
  );

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  function automatic bit [31:0] sram_val(input logic [31:0] a);
    return smem.exists(a[31:2]) ? smem[a[31:2]] : a ^ 32'h9E3779B9;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 0;
      mv[s][1] = 0;
      ml[s] = 0;
    end
  endtask

  task automatic op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] wd, input string nm);
    int stall, rdc, wrc, idx;
    bit h, hw, v;
    logic [31:0] got, sa, swd;
    idx = int'(a[7:2]);
    h = 0;
    hw = 0;
    for (int k = 0; k < 2; k++)
      if (mv[idx][k] && mt[idx][k] == a[17:8]) begin
        h = 1;
        hw = k[0];
      end
    @(negedge clk);
    mem_wr_en = w;
    mem_rd_en = r;
    address = a;
    write_data = wd;
    sram_read_data = sram_val(a);
    #1;
    stall = 0;
    rdc = 0;
    wrc = 0;
    while (freeze && stall < 40) begin
      rdc += int'(sram_rd_en);
      wrc += int'(sram_wr_en);
      @(negedge clk);
      #1;
      stall++;
    end
    rdc += int'(sram_rd_en);
    wrc += int'(sram_wr_en);
    got = read_data;
    sa = sram_address;
    swd = sram_write_data;
    @(posedge clk);
    #1;
    mem_wr_en = 0;
    mem_rd_en = 0;
    if (w) begin
      check({nm, ":wr_stall"}, stall, 6);
      check({nm, ":wr_rd_en"}, rdc, 0);
      check({nm, ":wr_wr_en"}, wrc, 6);
      check({nm, ":wr_addr"}, sa, a);
      check({nm, ":wr_data"}, swd, wd);
      smem[a[31:2]] = wd;
      if (h) begin
        md[idx][hw] = wd;
        ml[idx] = ~hw;
      end
    end else if (h) begin
      check({nm, ":hit_stall"}, stall, 0);
      check({nm, ":hit_rd_en"}, rdc, 0);
      check({nm, ":hit_data"}, got, md[idx][hw]);
      ml[idx] = ~hw;
    end else begin
      check({nm, ":miss_stall"}, stall, 6);
      check({nm, ":miss_rd_en"}, rdc, 6);
      check({nm, ":miss_wr_en"}, wrc, 0);
      check({nm, ":miss_data"}, got, sram_val(a));
      check({nm, ":miss_addr"}, sa, a);
      v = !mv[idx][0] ? 1'b0 : !mv[idx][1] ? 1'b1 : ml[idx];
      mv[idx][v] = 1;
      mt[idx][v] = a[17:8];
      md[idx][v] = sram_val(a);
      ml[idx] = ~v;
    end
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    clear_model();
    smem[30'h100] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #1;
    check("rst:freeze", freeze, 0);
    check("rst:rd_en", sram_rd_en, 0);
    check("rst:wr_en", sram_wr_en, 0);
    check("rst:addr", sram_address, 0);
    check("rst:wdata", sram_write_data, 0);
    check("rst:rdata", read_data, 0);
    rst = 1;
    op(0, 1, 32'h400, 0, "rd400_miss");
    op(0, 1, 32'h400, 0, "rd400_hit");
    op(0, 1, 32'h500, 0, "rd500");
    op(0, 1, 32'h600, 0, "rd600_evict");
    op(0, 1, 32'h400, 0, "rd400_again");
    op(1, 0, 32'h400, 32'h12345678, "wr400");
    op(0, 1, 32'h400, 0, "rd400_after_wr");
    op(1, 0, 32'h700, 32'hCAFEF00D, "wr700");
    op(0, 1, 32'h700, 0, "rd700");
    op(1, 1, 32'h404, 32'hA5A55A5A, "both404");
    for (int i = 0; i < 160; i++) begin
      a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      op(kind < 4, kind >= 3, a, $urandom, "rand");
    end
    @(negedge clk);
    mem_rd_en = 1;
    address = 32'h800;
    sram_read_data = sram_val(address);
    repeat (3) @(negedge clk);
    #1;
    check("mid:pre_freeze", freeze, 1);
    check("mid:pre_rd_en", sram_rd_en, 1);
    rst = 0;
    #1;
    check("mid:freeze", freeze, 0);
    check("mid:rd_en", sram_rd_en, 0);
    check("mid:wr_en", sram_wr_en, 0);
    check("mid:addr", sram_address, 0);
    mem_rd_en = 0;
    clear_model();
    @(negedge clk);
    rst = 1;
    op(0, 1, 32'h400, 0, "post_rst400");
    op(0, 1, 32'h404, 0, "post_rst404");
    op(0, 1, 32'h400, 0, "post_rst400_hit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_cache.md
# mem_cache

Two-way set-associative, write-through, no-write-allocate data cache between the MEM pipeline stage and the SRAM controller. Serves read hits in the same cycle. On a read miss or any write it freezes the pipeline, runs one SRAM transaction, and releases the pipeline when the controller signals ready. It is the only master of the SRAM controller request interface.

## Interface
Parameters:
- SETS, 64, number of sets (power of two)
- INDEX_W, 6, log2(SETS); index = address[INDEX_W+1:2]
- TAG_W, 10, tag = address[INDEX_W+TAG_W+1:INDEX_W+2] (address[17:8] at defaults)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_rd_en  in  1  pipeline read request
- mem_wr_en  in  1  pipeline write request; wins if both asserted
- address  in  32  byte address, word aligned (bits [1:0] ignored)
- write_data  in  32  write data
- read_data  out  32  read result, valid when mem_rd_en && !freeze
- freeze  out  1  stall to pipeline, combinational
- sram_rd_en  out  1  controller read request
- sram_wr_en  out  1  controller write request
- sram_address  out  32  latched request address, passed unmodified
- sram_write_data  out  32  latched write data
- sram_read_data  in  32  controller read data, valid when sram_ready=1
- sram_ready  in  1  controller done/idle

## Operation
- Storage per set: two ways, each {valid, tag[TAG_W-1:0], data[31:0]}, plus one LRU bit. LRU=0 means way 0 is the next victim.
- Hit: valid && tag match in either way. Both ways matching is impossible by construction.
- FSM states: IDLE, RD_MISS, WR_THRU.
  - IDLE, rd, hit: read_data = hit way data; freeze=0; LRU points to the other way; stay in IDLE.
  - IDLE, rd, miss: latch address; freeze=1; go to RD_MISS.
  - IDLE, wr (hit or miss): latch address and write_data; freeze=1; go to WR_THRU.
  - RD_MISS: sram_rd_en=1; freeze=1 while sram_ready=0.
    - When sram_ready=1: write sram_read_data and the latched tag into the victim way (invalid way first, way 0 if both invalid, else the LRU way); set valid; LRU points to the other way; drive read_data = sram_read_data; freeze=0; go to IDLE.
  - WR_THRU: sram_wr_en=1; freeze=1 while sram_ready=0.
    - When sram_ready=1: if the latched address hits, update that way's data and LRU; a miss does not allocate. freeze=0; go to IDLE.
- sram_rd_en and sram_wr_en are decoded from state only. They are never both 1 and are 0 in IDLE.
- Upstream inputs are ignored outside IDLE. Only latched values drive the SRAM side.
- No request in IDLE: freeze=0, no state change. read_data = way 0 data of the indexed set; don't-care.

## Timing
- Reset (rst=0, async): state=IDLE; all valid and LRU bits cleared. freeze=0, sram_rd_en=0, sram_wr_en=0, sram_address=0, sram_write_data=0. read_data=0 while all ways are invalid.
- Read hit: 0-cycle latency.
- Miss or write:
  - Detected in cycle c0, freeze high from c0.
  - SRAM enable high from c1 until and including the cycle sram_ready=1 (cN).
  - freeze low in cN; state is IDLE at cN+1.
  - The enable drops at cN+1, so the controller never sees a back-to-back restart.
- The controller asserts sram_ready 5 cycles after it first samples an enable. A miss therefore stalls 6 cycles (c0–c5) and completes in c6.
- sram_ready=1 while the cache is in IDLE is ignored.
- Reset mid-transaction: FSM and tags clear immediately and enables drop. The SRAM controller is reset by the same rst.

## Structure
- Package cache_pkg holds:
  - state encoding (IDLE=2'd0, RD_MISS=2'd1, WR_THRU=2'd2)
  - defaults SETS, INDEX_W, TAG_W
  - helper functions for index and tag extraction
- Sub-module cache_set_store holds the valid/tag/data/LRU register arrays.
  - Inputs: index, plus fill/update enables with way select.
  - Outputs: both ways' valid/tag/data and LRU for the indexed set.
- mem_cache keeps the FSM, hit logic, victim selection and latches.

## Test plan
- Reset, then read 0x400 (index 0, tag 4) with SRAM model returning 0xDEADBEEF: freeze=1 for c0–c5, sram_rd_en=1 for c1–c6, read_data=0xDEADBEEF with freeze=0 in c6. Re-reading 0x400 then hits with 0 stall.
- Read 0x500 (index 0, tag 5) after the above: fills way 1. Then read 0x600 (tag 6): evicts tag 4 (LRU), and a re-read of 0x400 misses.
- Write 0x400 = 0x12345678 while cached: freeze for 6 cycles, sram_wr_en=1, sram_write_data=0x12345678. A subsequent read of 0x400 hits with 0x12345678 and no SRAM access.
- Write 0x700 (not cached): goes through to SRAM, no allocation. A read of 0x700 then misses.
- mem_rd_en and mem_wr_en both high: write path taken, sram_rd_en stays 0.
- Reset asserted in cycle c3 of a read miss: enables and freeze go 0 immediately and all lines are invalid. After release, read 0x400 misses.
